keycode_event_queue: RTL

//  Consumes the six 8-bit keycode PIO exports of the NIOS SoC (keycode1..6) and turns

---
 rtl/keycode_event_queue.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/keycode_event_queue.sv
// Turns changes in the six held-keycode PIO slots into press/release events queued in a FIFO.
// Optional build macro KEYEVT_DROP_EN: discard events when the FIFO is full and count the drops.
module keycode_event_queue #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [7:0]       keycode1,
  input  logic [7:0]       keycode2,
  input  logic [7:0]       keycode3,
  input  logic [7:0]       keycode4,
  input  logic [7:0]       keycode5,
  input  logic [7:0]       keycode6,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [8:0]       evt_data,
  output logic [FIFO_AW:0] evt_count,
`ifdef KEYEVT_DROP_EN
  output logic [7:0]       evt_drops,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SCAN_P, SCAN_R, COMMIT} state_t;

  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [7:0]         kc_in [6];
  logic [7:0]         in_q  [6];
  logic [7:0]         cur   [6];
  logic [7:0]         prev  [6];
  state_t             state, state_n;
  logic [2:0]         idx, idx_n;
  logic               load_cur, commit;
  logic               changed, rollover;

  logic [7:0]         cand, own, other;
  logic               in_other, dup, want_push, push_ok, push, pop, stall;
  logic [8:0]         push_data;

  logic [8:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [FIFO_AW:0]   count, count_n;
  logic [8:0]         head_q, head_n;
`ifdef KEYEVT_DROP_EN
  logic               drop_ev;
  logic [7:0]         drops_q;
`endif

  assign kc_in = '{keycode1, keycode2, keycode3, keycode4, keycode5, keycode6};

  always_comb begin
    changed  = 1'b0;
    rollover = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (in_q[i] != prev[i]) changed  = 1'b1;
      if (in_q[i] == 8'h01)   rollover = 1'b1;
    end
  end

  // SCAN_P looks at cur against prev; SCAN_R swaps the roles of the two snapshots.
  always_comb begin
    cand     = '0;
    own      = '0;
    other    = '0;
    in_other = 1'b0;
    dup      = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      own = (state == SCAN_R) ? prev[i] : cur[i];
      if (idx == 3'(i)) cand = own;
    end
    for (int unsigned i = 0; i < 6; i++) begin
      own   = (state == SCAN_R) ? prev[i] : cur[i];
      other = (state == SCAN_R) ? cur[i]  : prev[i];
      if (other == cand)                 in_other = 1'b1;
      if (3'(i) < idx && own == cand)    dup      = 1'b1;
    end
    want_push = (state == SCAN_P || state == SCAN_R) && cand != '0 && !in_other && !dup;
    push_data = {state == SCAN_P, cand};
  end

  assign pop     = evt_valid & evt_ready;
  assign push_ok = (count < DEPTH) | pop;
  assign push    = want_push & push_ok;
`ifdef KEYEVT_DROP_EN
  assign stall   = 1'b0;
  assign drop_ev = want_push & ~push_ok;
`else
  assign stall   = want_push & ~push_ok;
`endif

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    load_cur = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (changed && !rollover) begin
          load_cur = 1'b1;
          idx_n    = '0;
          state_n  = SCAN_P;
        end
      end
      SCAN_P, SCAN_R: begin
        if (!stall) begin
          if (idx == 3'd5) begin
            idx_n   = '0;
            state_n = (state == SCAN_P) ? SCAN_R : COMMIT;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The head register takes the pushed word directly when the queue would otherwise be empty.
  always_comb begin
    count_n  = count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    rd_ptr_n = rd_ptr + FIFO_AW'(pop);
    head_n   = head_q;
    if (count_n != '0) begin
      head_n = (count == (FIFO_AW+1)'(pop)) ? push_data : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      in_q   <= '{default: '0};
      cur    <= '{default: '0};
      prev   <= '{default: '0};
      state  <= IDLE;
      idx    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      in_q  <= kc_in;
      state <= state_n;
      idx   <= idx_n;
      if (load_cur) cur  <= in_q;
      if (commit)   prev <= cur;
      if (push)     wr_ptr <= wr_ptr + FIFO_AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      head_q <= head_n;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef KEYEVT_DROP_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                 drops_q <= '0;
    else if (drop_ev && drops_q != '1)  drops_q <= drops_q + 8'd1;
  end
  assign evt_drops = drops_q;
`endif

  assign evt_valid = (count != '0);
  assign evt_data  = head_q;
  assign evt_count = count;
  assign busy      = (state != IDLE);

endmodule
